// File: rtl/riscv_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and grant selectors.
// Pure declarations; no timing or flow-control behaviour lives here.
// Default datapath width matches the 32-bit core.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/arb_fairness_counter.sv
// Saturating count of data grants taken while fetch was waiting; at_max forces a fetch grant.
// Latency: count updates one cycle after inc/clr; at_max is a decode of the registered count.
// No backpressure; clr wins over inc.
module arb_fairness_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = 4;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between fetch reads and load/store accesses.
// Latency: request in IDLE -> mem_en next cycle; mem_ready -> done pulse next cycle (min 2 cycles).
// Backpressure: requesters hold req+payload until their done pulse; port held stable until mem_ready.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;

    logic if_elig;
    logic dm_elig;
    logic grant_vld;
    logic grant_sel;
    logic cnt_inc;
    logic cnt_clr;
    logic at_max;

    // A requester whose completion pulse is showing is still holding req; don't re-grant it.
    always_comb begin
        if_elig   = if_req && !if_valid_q;
        dm_elig   = dm_req && !dm_done_q;
        grant_vld = (state_q == IDLE) && (if_elig || dm_elig);
        grant_sel = (if_elig && (!dm_elig || at_max)) ? GRANT_IF : GRANT_DM;
        cnt_clr   = grant_vld && (grant_sel == GRANT_IF);
        cnt_inc   = grant_vld && (grant_sel == GRANT_DM) && if_elig;
    end

    arb_fairness_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fairness (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .at_max (at_max)
    );

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_done_d   = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    mem_en_d = 1'b1;
                    if (grant_sel == GRANT_IF) begin
                        state_d     = SERVE_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end else begin
                        state_d     = SERVE_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end
                end
            end
            SERVE_IF: begin
                if (mem_ready && mem_en_q) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            SERVE_DM: begin
                if (mem_ready && mem_en_q) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = mem_we_q ? '0 : mem_rdata;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_done_q   <= dm_done_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a transaction-level arbitration model and scoreboard.
// The driver advances the model per clock; a negedge monitor pops expected grants/completions.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [BW-1:0] dm_be;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } acc_t;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } done_t;

    acc_t  exp_acc[$];
    done_t exp_if[$];
    done_t exp_dm[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: 0 = port free, 1 = serving fetch, 2 = serving data.
    int unsigned cyc = 0;
    int          m_state = 0;
    int          m_cnt = 0;
    bit          m_ifv = 1'b0;
    bit          m_dmd = 1'b0;
    bit          m_cur_we = 1'b0;
    bit          m_busy = 1'b0;
    bit          rst_seen = 1'b0;
    bit          end_req = 1'b0;
    int          n_if = 0;
    int          n_dm = 0;

    // Driver knobs.
    bit          auto_if = 1'b0;
    bit          auto_dm = 1'b0;
    int          ready_mode = 0;
    bit          fixed_rdata_en = 1'b0;
    logic [DW-1:0] fixed_rdata = '0;
    int          srv_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit    if_el;
        bit    dm_el;
        bit    nifv;
        bit    ndmd;
        acc_t  a;
        done_t d;
        nifv = 1'b0;
        ndmd = 1'b0;
        cyc++;
        if (rst) begin
            m_state  = 0;
            m_cnt    = 0;
            m_ifv    = 1'b0;
            m_dmd    = 1'b0;
            m_busy   = 1'b0;
            rst_seen = 1'b1;
            return;
        end
        rst_seen = 1'b0;
        if_el = if_req && !m_ifv;
        dm_el = dm_req && !m_dmd;
        if (m_state == 0) begin
            if (if_el && (!dm_el || m_cnt == SM)) begin
                m_cnt   = 0;
                a.we    = 1'b0;
                a.addr  = if_addr;
                a.wdata = '0;
                a.be    = '1;
                m_state = 1;
                exp_acc.push_back(a);
            end else if (dm_el) begin
                if (if_el) m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
                a.we     = dm_we;
                a.addr   = dm_addr;
                a.wdata  = dm_wdata;
                a.be     = dm_be;
                m_cur_we = dm_we;
                m_state  = 2;
                exp_acc.push_back(a);
            end
        end else if (mem_ready) begin
            d.cyc = cyc;
            if (m_state == 1) begin
                d.data = mem_rdata;
                exp_if.push_back(d);
                nifv = 1'b1;
                n_if++;
            end else begin
                d.data = m_cur_we ? '0 : mem_rdata;
                exp_dm.push_back(d);
                ndmd = 1'b1;
                n_dm++;
            end
            m_state = 0;
        end
        m_ifv  = nifv;
        m_dmd  = ndmd;
        m_busy = (m_state != 0);
    endtask

    task automatic drive_req();
        if (m_ifv) if_req = 1'b0;
        if (m_dmd) dm_req = 1'b0;
        if (auto_if && !if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (auto_dm && !dm_req && $urandom_range(0, 1) == 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom);
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
            dm_be    = BW'($urandom);
        end
        // Payload wiggles on the requester being served must not reach the port.
        if (m_state == 1 && $urandom_range(0, 3) == 0) if_addr = $urandom;
        if (m_state == 2 && $urandom_range(0, 3) == 0) begin
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_be    = BW'($urandom);
        end
    endtask

    task automatic drive_mem();
        srv_cnt = m_busy ? srv_cnt + 1 : 0;
        case (ready_mode)
            0:       mem_ready = 1'b0;
            1:       mem_ready = 1'b1;
            2:       mem_ready = (srv_cnt >= 3);
            default: mem_ready = ($urandom_range(0, 2) == 0);
        endcase
        mem_rdata = fixed_rdata_en ? fixed_rdata : $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        drive_req();
        drive_mem();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) step();
        rst = 1'b0;

        // Fetch alone with the memory always ready.
        ready_mode = 1; fixed_rdata_en = 1'b1; fixed_rdata = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (5) step();

        // Simultaneous fetch and load: load first, fetch right after.
        fixed_rdata_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        repeat (7) step();

        // Store with a slow memory.
        ready_mode = 2;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        repeat (8) step();

        // Reset in the middle of a data access abandons it.
        ready_mode = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        repeat (3) step();
        rst = 1'b1; dm_req = 1'b0;
        step();
        rst = 1'b0;

        // Stray mem_ready while idle with nothing requested.
        ready_mode = 3;
        repeat (12) step();

        // Random traffic from both requesters.
        auto_if = 1'b1; auto_dm = 1'b1;
        repeat (3000) step();

        auto_if = 1'b0; auto_dm = 1'b0; ready_mode = 1;
        repeat (20) step();
        end_req = 1'b1;
        repeat (3) step();
        $display("FAIL end_of_test: monitor did not conclude");
        $fatal(1, "bench end not reached");
    end

    acc_t        cur;
    done_t       dd;
    acc_t        stale;
    bit          prev_en = 1'b0;
    logic [DW-1:0] last_if = '0;
    logic [DW-1:0] last_dm = '0;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_ctrl", 64'({mem_en, mem_we, mem_be, if_valid, dm_done, busy}), 64'd0);
            chk("rst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
            chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
            prev_en = 1'b0;
            last_if = '0;
            last_dm = '0;
        end else begin
            chk("mem_en", 64'(mem_en), 64'(m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            if (mem_en && !prev_en) begin
                if (exp_acc.size() == 0) begin
                    chk("grant_unexpected", 64'd1, 64'd0);
                end else begin
                    cur = exp_acc.pop_front();
                    chk("grant_we_be_addr", 64'({mem_we, mem_be, mem_addr}), 64'({cur.we, cur.be, cur.addr}));
                    if (cur.we) chk("grant_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
            end else if (mem_en) begin
                chk("port_stable", 64'({mem_we, mem_be, mem_addr}), 64'({cur.we, cur.be, cur.addr}));
                if (cur.we) chk("port_wdata_stable", 64'(mem_wdata), 64'(cur.wdata));
            end
            while (exp_acc.size() > 0) begin
                stale = exp_acc.pop_front();
                chk("grant_missing", 64'(stale.addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end
            prev_en = mem_en;

            while (exp_if.size() > 0 && exp_if[0].cyc < cyc) begin
                dd = exp_if.pop_front();
                chk("if_valid_missing", 64'd0, 64'd1);
            end
            if (if_valid) begin
                if (exp_if.size() == 0) begin
                    chk("if_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    dd = exp_if.pop_front();
                    chk("if_valid_cycle", 64'(cyc), 64'(dd.cyc));
                    chk("if_rdata", 64'(if_rdata), 64'(dd.data));
                    last_if = dd.data;
                end
            end else begin
                chk("if_rdata_hold", 64'(if_rdata), 64'(last_if));
            end

            while (exp_dm.size() > 0 && exp_dm[0].cyc < cyc) begin
                dd = exp_dm.pop_front();
                chk("dm_done_missing", 64'd0, 64'd1);
            end
            if (dm_done) begin
                if (exp_dm.size() == 0) begin
                    chk("dm_done_unexpected", 64'd1, 64'd0);
                end else begin
                    dd = exp_dm.pop_front();
                    chk("dm_done_cycle", 64'(cyc), 64'(dd.cyc));
                    chk("dm_rdata", 64'(dm_rdata), 64'(dd.data));
                    last_dm = dd.data;
                end
            end else begin
                chk("dm_rdata_hold", 64'(dm_rdata), 64'(last_dm));
            end
        end

        if (end_req) begin
            chk("if_queue_empty", 64'(exp_if.size()), 64'd0);
            chk("dm_queue_empty", 64'(exp_dm.size()), 64'd0);
            chk("traffic_progress", 64'((n_if > 20) && (n_dm > 20)), 64'd1);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

endmodule
